// File: rtl/tpu_maxpool.sv
// 2x2 stride-2 signed max-pooling of a flattened IN_DIM x IN_DIM map, registered.
// Define MAXPOOL_RELU_EN to clamp negative pooled maxima to zero (fused ReLU).
module tpu_maxpool #(
  parameter int IN_DIM  = 24,
  parameter int OUT_DIM = IN_DIM / 2,
  parameter int DATA_W  = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  input  logic [IN_DIM*IN_DIM*DATA_W-1:0]     tensor_in,
  output logic [OUT_DIM*OUT_DIM*DATA_W-1:0]   tensor_out,
  output logic                                out_valid
);

  function automatic logic signed [DATA_W-1:0] smax(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  function automatic logic signed [DATA_W-1:0] act(input logic signed [DATA_W-1:0] v);
`ifdef MAXPOOL_RELU_EN
    return v[DATA_W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  logic [OUT_DIM*OUT_DIM*DATA_W-1:0] w_pool_p0;
  logic [OUT_DIM*OUT_DIM*DATA_W-1:0] r_pool_p1;
  logic                              r_vld_p1;

  // p0: every window reduced in parallel by a two-level comparator tree
  for (genvar gr = 0; gr < OUT_DIM; gr++) begin : g_row
    for (genvar gc = 0; gc < OUT_DIM; gc++) begin : g_col
      logic signed [DATA_W-1:0] w_a, w_b, w_c, w_d, w_max;
      assign w_a   = tensor_in[((2*gr)*IN_DIM + 2*gc)*DATA_W     +: DATA_W];
      assign w_b   = tensor_in[((2*gr)*IN_DIM + 2*gc + 1)*DATA_W +: DATA_W];
      assign w_c   = tensor_in[((2*gr+1)*IN_DIM + 2*gc)*DATA_W   +: DATA_W];
      assign w_d   = tensor_in[((2*gr+1)*IN_DIM + 2*gc + 1)*DATA_W +: DATA_W];
      assign w_max = smax(smax(w_a, w_b), smax(w_c, w_d));
      assign w_pool_p0[(gr*OUT_DIM + gc)*DATA_W +: DATA_W] = act(w_max);
    end
  end

  // p1: output register; data holds when no valid map is presented
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pool_p1 <= '0;
      r_vld_p1  <= 1'b0;
    end else begin
      r_vld_p1 <= in_valid;
      if (in_valid) r_pool_p1 <= w_pool_p0;
    end
  end

  assign tensor_out = r_pool_p1;
  assign out_valid  = r_vld_p1;

endmodule

// File: tb/tb_tpu_maxpool.sv
// Directed self-checking bench for tpu_maxpool (default 24x24 -> 12x12, 8-bit).
module tb_tpu_maxpool;
  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [4607:0] tensor_in;
  logic [1151:0] tensor_out;
  logic          out_valid;
  logic [1151:0] exp_out;
  int            n_cmp;
  int            n_fail;

  tpu_maxpool dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .tensor_in  (tensor_in),
    .tensor_out (tensor_out),
    .out_valid  (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_el(input int r, input int c, input logic [7:0] v);
    tensor_in[(r*24 + c)*8 +: 8] = v;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 576; i++) tensor_in[i*8 +: 8] = v;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; tensor_in = '0;
    @(negedge clk);
    n_cmp++;
    if (tensor_out !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", tensor_out); end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_striped();
    for (int r = 0; r < 24; r++)
      for (int c = 0; c < 24; c++)
        set_el(r, c, (r % 2 == 0) ? ((c % 2 == 0) ? 8'h55 : 8'hA8)
                                  : ((c % 2 == 0) ? 8'h75 : 8'h28));
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    exp_out = {144{8'h75}};
    n_cmp++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL striped_valid got %b want 1", out_valid); end
    n_cmp++;
    if (tensor_out !== exp_out) begin n_fail++; $display("FAIL striped_data got %h want %h", tensor_out, exp_out); end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL striped_pulse got %b want 0", out_valid); end
  endtask

  task automatic test_sign_boundary();
    for (int r = 0; r < 24; r++)
      for (int c = 0; c < 24; c++)
        set_el(r, c, (r % 2 == 0) ? ((c % 2 == 0) ? 8'h80 : 8'h7F)
                                  : ((c % 2 == 0) ? 8'hFF : 8'h00));
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    exp_out = {144{8'h7F}};
    n_cmp++;
    if (tensor_out !== exp_out) begin n_fail++; $display("FAIL sign_boundary got %h want %h", tensor_out, exp_out); end
  endtask

  task automatic test_all_negative();
    fill(8'h80);
    set_el(0, 1, 8'hFE);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
`ifdef MAXPOOL_RELU_EN
    exp_out = '0;
`else
    exp_out = {144{8'h80}};
    exp_out[7:0] = 8'hFE;
`endif
    n_cmp++;
    if (tensor_out !== exp_out) begin n_fail++; $display("FAIL all_negative got %h want %h", tensor_out, exp_out); end
  endtask

  task automatic test_position();
    fill(8'h00);
    set_el(23, 23, 8'h11);
    set_el(2, 5, 8'h22);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    exp_out = '0;
    exp_out[1151:1144] = 8'h11;
    exp_out[14*8 +: 8] = 8'h22;
    n_cmp++;
    if (tensor_out[1151:1144] !== 8'h11) begin n_fail++; $display("FAIL position_top got %h want 11", tensor_out[1151:1144]); end
    n_cmp++;
    if (tensor_out !== exp_out) begin n_fail++; $display("FAIL position_map got %h want %h", tensor_out, exp_out); end
  endtask

  task automatic test_back_to_back();
    fill(8'h10);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    exp_out = {144{8'h10}};
    n_cmp++;
    if (tensor_out !== exp_out) begin n_fail++; $display("FAIL hold_load_a got %h want %h", tensor_out, exp_out); end
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 144; i++) tensor_in[i*32 +: 32] = $urandom;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_valid_%0d got %b want 0", k, out_valid); end
      n_cmp++;
      if (tensor_out !== exp_out) begin n_fail++; $display("FAIL hold_data_%0d got %h want %h", k, tensor_out, exp_out); end
    end
    fill(8'h20);
    set_el(1, 1, 8'h7F);
    in_valid = 1'b1;
    @(negedge clk);
    exp_out = {144{8'h20}};
    exp_out[7:0] = 8'h7F;
    n_cmp++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid_b got %b want 1", out_valid); end
    n_cmp++;
    if (tensor_out !== exp_out) begin n_fail++; $display("FAIL b2b_data_b got %h want %h", tensor_out, exp_out); end
    fill(8'h30);
    set_el(22, 0, 8'h31);
    @(negedge clk);
    in_valid = 1'b0;
    exp_out = {144{8'h30}};
    exp_out[132*8 +: 8] = 8'h31;
    n_cmp++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid_c got %b want 1", out_valid); end
    n_cmp++;
    if (tensor_out !== exp_out) begin n_fail++; $display("FAIL b2b_data_c got %h want %h", tensor_out, exp_out); end
  endtask

  task automatic test_async_reset();
    fill(8'h44);
    in_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (tensor_out !== {144{8'h44}}) begin n_fail++; $display("FAIL areset_pre got %h want all 44", tensor_out); end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (tensor_out !== '0) begin n_fail++; $display("FAIL areset_data got %h want 0", tensor_out); end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid got %b want 0", out_valid); end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || tensor_out !== '0) begin
      n_fail++; $display("FAIL areset_after got vld=%b data=%h want 0/0", out_valid, tensor_out);
    end
    fill(8'h05);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || tensor_out !== {144{8'h05}}) begin
      n_fail++; $display("FAIL areset_resume got vld=%b data=%h want 1/all 05", out_valid, tensor_out);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_striped();
    test_sign_boundary();
    test_all_negative();
    test_position();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
